dma_capture_ctrl: RTL and testbench
===================================

DMA_CAPTURE_CTRL -- requirements
Module: dma_capture_ctrl

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 20, width of the capture-length field.
REQ-002 SHALL have parameter DROP_WIDTH, default 16, width of the saturating drop counter.
REQ-003 SHALL have port rx_link_clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_enable, input, 1 bit: level arm/run request.
REQ-006 SHALL have port cfg_len, input, LEN_WIDTH bits: beats per capture; 0 selects continuous mode.
REQ-007 SHALL have port s_valid, input, 1 bit: sample beat valid from the DMA interface mux.
REQ-008 SHALL have port s_data, input, 64 bits: sample beat data.
REQ-009 SHALL have port fifo_wr_xfer_req, input, 1 bit: the DMA is requesting data.
REQ-010 SHALL have port fifo_wr_overflow, input, 1 bit: the DMA FIFO has overflowed.
REQ-011 SHALL have port fifo_wr_en, output, 1 bit: DMA write strobe.
REQ-012 SHALL have port fifo_wr_sync, output, 1 bit: marks the first beat of a capture.
REQ-013 SHALL have port fifo_wr_data, output, 64 bits: DMA write data.
REQ-014 SHALL have port sts_busy, output, 1 bit: high in WAIT_REQ or CAPTURE.
REQ-015 SHALL have port sts_done, output, 1 bit: the capture completed by count.
REQ-016 SHALL have port sts_abort, output, 1 bit: the capture ended by loss of xfer_req.
REQ-017 SHALL have port sts_ovf, output, 1 bit: sticky DMA overflow flag.
REQ-018 SHALL have port sts_beat_cnt, output, 32 bits: beats written in the current capture.
REQ-019 SHALL have port sts_drop_cnt, output, DROP_WIDTH bits: valid beats discarded since arm.

Function
REQ-020 SHALL implement four states: IDLE, WAIT_REQ, CAPTURE and DONE.
REQ-021 SHALL transition IDLE->WAIT_REQ on a rising edge of cfg_enable, registered against its previous value.
REQ-022 SHALL latch cfg_len on the IDLE->WAIT_REQ transition (arm) and SHALL ignore cfg_len changes until the next arm.
REQ-023 SHALL, on arm, clear sts_beat_cnt, sts_drop_cnt, sts_ovf, sts_done and sts_abort.
REQ-024 SHALL transition WAIT_REQ->CAPTURE in the cycle after fifo_wr_xfer_req is sampled high.
REQ-025 SHALL transition CAPTURE->DONE with sts_done=1 in the cycle after the accepted beat that makes the beat count equal the latched length, when the latched length is nonzero.
REQ-026 SHALL transition CAPTURE->DONE with sts_abort=1 if fifo_wr_xfer_req is sampled low in CAPTURE and completion does not occur in the same cycle.
REQ-027 SHALL give completion priority over abort when both occur in the same cycle.
REQ-028 SHALL transition DONE->IDLE when cfg_enable=0.
REQ-029 SHALL transition from any state to IDLE in the next cycle when cfg_enable=0, leaving sts_done and sts_abort unchanged.
REQ-030 SHALL accept a beat when s_valid=1 in CAPTURE, and SHALL drive fifo_wr_en=1 with fifo_wr_data=s_data exactly one cycle later.
REQ-031 SHALL accept a beat presented on the completing cycle, that beat being the last one written.
REQ-032 SHALL assert fifo_wr_sync only together with the first fifo_wr_en of each capture.
REQ-033 SHALL hold fifo_wr_en=0 and fifo_wr_sync=0 in IDLE, WAIT_REQ and DONE, except for the one-cycle-delayed final beat.
REQ-034 SHALL leave fifo_wr_data unchanged when no beat is accepted.
REQ-035 SHALL increment sts_drop_cnt for every s_valid beat seen in WAIT_REQ or DONE, saturating at all-ones.
REQ-036 SHALL set sts_ovf on any cycle in which fifo_wr_overflow=1, in any state, and SHALL clear it only on arm or reset.
REQ-037 SHALL increment sts_beat_cnt once per accepted beat, wrapping modulo 2^32.
REQ-038 SHALL, in continuous mode (latched length 0), never complete by count and end only by abort or disable.
REQ-039 SHALL drive sts_busy combinationally from the state.

Reset
REQ-040 SHALL, while rst_n=0, hold the state at IDLE and the registered previous cfg_enable at 0.
REQ-041 SHALL, while rst_n=0, hold all outputs and counters at 0, including fifo_wr_data.
REQ-042 SHALL, on reset asserted mid-capture, drop the pending delayed beat.
REQ-043 SHALL, after reset release with cfg_enable already high, not arm until cfg_enable sees a fresh 0->1 edge.

Verification
REQ-044 Bench SHALL cover basic capture: cfg_len=4, arm, xfer_req=1, six consecutive valid beats D0..D5 -> exactly D0..D3 written, wr_sync with D0 only, sts_done=1, sts_beat_cnt=4, sts_drop_cnt=2.
REQ-045 Bench SHALL cover latency: a single beat 0xA5A5... on cycle N in CAPTURE -> fifo_wr_en=1 with that data on cycle N+1 only.
REQ-046 Bench SHALL cover pre-request drops: three valid beats in WAIT_REQ, then xfer_req -> sts_drop_cnt=3 and first written beat carries wr_sync.
REQ-047 Bench SHALL cover abort versus completion: cfg_len=8, xfer_req drops after 5 beats -> sts_abort=1, sts_beat_cnt=5; repeat with xfer_req dropping on the 8th-beat cycle -> sts_done=1, sts_abort=0.
REQ-048 Bench SHALL cover overflow and continuous mode: cfg_len=0, 100 beats, 1-cycle overflow pulse -> 100 writes, sts_ovf=1 sticky; re-arm clears it.
REQ-049 Bench SHALL cover reset mid-capture: rst_n low during CAPTURE with cfg_enable held high -> all outputs 0, no arm until cfg_enable toggles low then high.

Source files
------------

// File: rtl/dma_capture_ctrl_if.sv
// Sample-stream, DMA FIFO write and status bundle for dma_capture_ctrl.
// slave is the controller's view; master is the view of whoever drives it.
interface dma_capture_ctrl_if #(
    parameter int unsigned LEN_WIDTH  = 20,
    parameter int unsigned DROP_WIDTH = 16
) ();
    logic                  cfg_enable;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic                  s_valid;
    logic [63:0]           s_data;
    logic                  fifo_wr_xfer_req;
    logic                  fifo_wr_overflow;
    logic                  fifo_wr_en;
    logic                  fifo_wr_sync;
    logic [63:0]           fifo_wr_data;
    logic                  sts_busy;
    logic                  sts_done;
    logic                  sts_abort;
    logic                  sts_ovf;
    logic [31:0]           sts_beat_cnt;
    logic [DROP_WIDTH-1:0] sts_drop_cnt;

    modport slave (
        input  cfg_enable, cfg_len, s_valid, s_data, fifo_wr_xfer_req, fifo_wr_overflow,
        output fifo_wr_en, fifo_wr_sync, fifo_wr_data, sts_busy, sts_done, sts_abort,
               sts_ovf, sts_beat_cnt, sts_drop_cnt
    );

    modport master (
        output cfg_enable, cfg_len, s_valid, s_data, fifo_wr_xfer_req, fifo_wr_overflow,
        input  fifo_wr_en, fifo_wr_sync, fifo_wr_data, sts_busy, sts_done, sts_abort,
               sts_ovf, sts_beat_cnt, sts_drop_cnt
    );
endinterface

// File: rtl/dma_capture_ctrl.sv
// Capture controller: arms on a cfg_enable rising edge, waits for the DMA request,
// then forwards sample beats to the DMA FIFO one cycle after acceptance.
module dma_capture_ctrl #(
    parameter int unsigned LEN_WIDTH  = 20,
    parameter int unsigned DROP_WIDTH = 16
) (
    input logic               rx_link_clk,
    input logic               rst_n,
    dma_capture_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWaitReq, StCapture, StDone} state_e;

    state_e                r_state;
    logic                  r_en_prev;
    logic                  r_arm_ok;
    logic                  r_first;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [31:0]           r_beat_cnt;
    logic [DROP_WIDTH-1:0] r_drop_cnt;
    logic                  r_done;
    logic                  r_abort;
    logic                  r_ovf;
    logic                  r_wr_en;
    logic                  r_wr_sync;
    logic [63:0]           r_wr_data;

    logic                  w_arm;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_drop;
    logic [31:0]           w_beat_inc;

    // r_arm_ok blocks an arm straight out of reset while cfg_enable is still high.
    assign w_arm      = (r_state == StIdle) && bus.cfg_enable && !r_en_prev && r_arm_ok;
    assign w_accept   = (r_state == StCapture) && bus.s_valid;
    assign w_beat_inc = r_beat_cnt + 32'd1;
    assign w_complete = w_accept && (r_len != '0) && (w_beat_inc == 32'(r_len));
    assign w_drop     = ((r_state == StWaitReq) || (r_state == StDone)) && bus.s_valid;

    always_ff @(posedge rx_link_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_en_prev  <= 1'b0;
            r_arm_ok   <= 1'b0;
            r_first    <= 1'b0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_drop_cnt <= '0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_ovf      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_sync  <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_en_prev <= bus.cfg_enable;
            if (!bus.cfg_enable) begin
                r_arm_ok <= 1'b1;
            end

            r_wr_en   <= w_accept;
            r_wr_sync <= w_accept && r_first;
            if (w_accept) begin
                r_wr_data  <= bus.s_data;
                r_beat_cnt <= w_beat_inc;
                r_first    <= 1'b0;
            end

            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_WIDTH'(1);
            end

            if (w_arm) begin
                r_ovf <= bus.fifo_wr_overflow;
            end else if (bus.fifo_wr_overflow) begin
                r_ovf <= 1'b1;
            end

            // Disable wins over every transition and leaves done/abort as they were.
            if (!bus.cfg_enable) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_arm) begin
                            r_state    <= StWaitReq;
                            r_len      <= bus.cfg_len;
                            r_beat_cnt <= '0;
                            r_drop_cnt <= '0;
                            r_done     <= 1'b0;
                            r_abort    <= 1'b0;
                            r_first    <= 1'b1;
                        end
                    end
                    StWaitReq: begin
                        if (bus.fifo_wr_xfer_req) begin
                            r_state <= StCapture;
                        end
                    end
                    StCapture: begin
                        if (w_complete) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if (!bus.fifo_wr_xfer_req) begin
                            r_state <= StDone;
                            r_abort <= 1'b1;
                        end
                    end
                    StDone: begin
                        r_state <= StDone;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_wr_en   = r_wr_en;
    assign bus.fifo_wr_sync = r_wr_sync;
    assign bus.fifo_wr_data = r_wr_data;
    assign bus.sts_busy     = (r_state == StWaitReq) || (r_state == StCapture);
    assign bus.sts_done     = r_done;
    assign bus.sts_abort    = r_abort;
    assign bus.sts_ovf      = r_ovf;
    assign bus.sts_beat_cnt = r_beat_cnt;
    assign bus.sts_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dma_capture_ctrl.sv
// Bench for dma_capture_ctrl: a behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_dma_capture_ctrl;

    localparam int unsigned LenW    = 20;
    localparam int unsigned DropW   = 16;
    localparam int unsigned DropMax = (1 << DropW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dma_capture_ctrl_if #(.LEN_WIDTH(LenW), .DROP_WIDTH(DropW)) bus ();

    dma_capture_ctrl #(.LEN_WIDTH(LenW), .DROP_WIDTH(DropW)) dut (
        .rx_link_clk (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] wr_q[$];
    bit          sync_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Model: phase 0 idle, 1 waiting for request, 2 capturing, 3 finished.
    int          m_phase   = 0;
    bit          m_last_en = 1'b1;  // after reset an enable already high is not an edge
    int unsigned m_len     = 0;
    int unsigned m_beats   = 0;
    int unsigned m_drops   = 0;
    bit          m_done    = 1'b0;
    bit          m_abort   = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          m_first   = 1'b0;
    bit          m_wr_en   = 1'b0;
    bit          m_wr_sync = 1'b0;
    logic [63:0] m_wr_data = '0;

    task automatic model_reset();
        m_phase = 0; m_last_en = 1'b1; m_len = 0; m_beats = 0; m_drops = 0;
        m_done = 0; m_abort = 0; m_ovf = 0; m_first = 0;
        m_wr_en = 0; m_wr_sync = 0; m_wr_data = '0;
    endtask

    task automatic model_step();
        bit en;
        bit take;
        en   = bus.cfg_enable;
        take = (m_phase == 2) && bus.s_valid;
        m_wr_en   = take;
        m_wr_sync = take && m_first;
        if (take) begin
            m_wr_data = bus.s_data;
            m_beats   = m_beats + 1;
            m_first   = 0;
        end
        if ((m_phase == 1 || m_phase == 3) && bus.s_valid && m_drops < DropMax)
            m_drops = m_drops + 1;
        if (bus.fifo_wr_overflow) m_ovf = 1;
        if (!en) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (!m_last_en) begin
                m_phase = 1; m_len = int'(bus.cfg_len); m_beats = 0; m_drops = 0;
                m_done = 0; m_abort = 0; m_first = 1; m_ovf = bus.fifo_wr_overflow;
            end
        end else if (m_phase == 1) begin
            if (bus.fifo_wr_xfer_req) m_phase = 2;
        end else if (m_phase == 2) begin
            if (take && m_len != 0 && m_beats == m_len) begin
                m_phase = 3; m_done = 1;
            end else if (!bus.fifo_wr_xfer_req) begin
                m_phase = 3; m_abort = 1;
            end
        end
        m_last_en = en;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare and write monitor, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("wr_en",   64'(bus.fifo_wr_en),   64'(m_wr_en));
        chk("wr_sync", 64'(bus.fifo_wr_sync), 64'(m_wr_sync));
        chk("wr_data", bus.fifo_wr_data,      m_wr_data);
        chk("busy",    64'(bus.sts_busy),     64'(m_phase == 1 || m_phase == 2));
        chk("done",    64'(bus.sts_done),     64'(m_done));
        chk("abort",   64'(bus.sts_abort),    64'(m_abort));
        chk("ovf",     64'(bus.sts_ovf),      64'(m_ovf));
        chk("beats",   64'(bus.sts_beat_cnt), 64'(m_beats));
        chk("drops",   64'(bus.sts_drop_cnt), 64'(m_drops));
        if (bus.fifo_wr_en === 1'b1) begin
            wr_q.push_back(bus.fifo_wr_data);
            sync_q.push_back(bus.fifo_wr_sync);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        sync_q.delete();
    endtask

    initial begin
        logic [63:0] d [6];
        int nsync;
        d[0] = 64'h0000_0000_0000_00D0; d[1] = 64'h1111_0000_0000_00D1;
        d[2] = 64'h2222_0000_0000_00D2; d[3] = 64'h3333_0000_0000_00D3;
        d[4] = 64'h4444_0000_0000_00D4; d[5] = 64'h5555_0000_0000_00D5;

        bus.cfg_enable = 0; bus.cfg_len = '0; bus.s_valid = 0; bus.s_data = '0;
        bus.fifo_wr_xfer_req = 0; bus.fifo_wr_overflow = 0;
        #2 rst_n = 1'b0;
        step(3);
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("rst_busy",  64'(bus.sts_busy),   64'd0);
        chk("rst_data",  bus.fifo_wr_data,    64'd0);
        rst_n = 1'b1;
        step(2);

        // Basic capture of four beats out of six.
        clear_log();
        bus.cfg_len = 20'd4; bus.cfg_enable = 1; step(1);
        bus.fifo_wr_xfer_req = 1; step(1);
        for (int i = 0; i < 6; i++) begin
            bus.s_valid = 1; bus.s_data = d[i]; step(1);
        end
        bus.s_valid = 0; step(2);
        chk("basic_nwr", 64'(wr_q.size()), 64'd4);
        nsync = 0;
        for (int i = 0; i < wr_q.size() && i < 4; i++) begin
            chk("basic_data", wr_q[i], d[i]);
            nsync += int'(sync_q[i]);
        end
        if (sync_q.size() > 0) chk("basic_sync0", 64'(sync_q[0]), 64'd1);
        chk("basic_nsync", 64'(nsync), 64'd1);
        chk("basic_done",  64'(bus.sts_done),     64'd1);
        chk("basic_beats", 64'(bus.sts_beat_cnt), 64'd4);
        chk("basic_drops", 64'(bus.sts_drop_cnt), 64'd2);
        bus.cfg_enable = 0; bus.fifo_wr_xfer_req = 0; step(2);
        chk("dis_keep_done", 64'(bus.sts_done), 64'd1);
        chk("dis_busy",      64'(bus.sts_busy), 64'd0);

        // Single-beat latency.
        bus.cfg_len = 20'd4; bus.cfg_enable = 1; step(1);
        bus.fifo_wr_xfer_req = 1; step(2);
        chk("lat_pre", 64'(bus.fifo_wr_en), 64'd0);
        bus.s_valid = 1; bus.s_data = 64'hA5A5_A5A5_A5A5_A5A5; step(1);
        bus.s_valid = 0;
        chk("lat_en",   64'(bus.fifo_wr_en), 64'd1);
        chk("lat_data", bus.fifo_wr_data,    64'hA5A5_A5A5_A5A5_A5A5);
        step(1);
        chk("lat_post", 64'(bus.fifo_wr_en), 64'd0);
        chk("lat_hold", bus.fifo_wr_data,    64'hA5A5_A5A5_A5A5_A5A5);
        bus.cfg_enable = 0; bus.fifo_wr_xfer_req = 0; step(2);
        chk("lat_abort", 64'(bus.sts_abort), 64'd0);

        // Drops while waiting for the request.
        bus.cfg_len = 20'd2; bus.cfg_enable = 1; step(1);
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1; bus.s_data = 64'hBAD0 + 64'(i); step(1);
        end
        bus.s_valid = 0; bus.fifo_wr_xfer_req = 1; step(1);
        clear_log();
        bus.s_valid = 1; bus.s_data = 64'hE0; step(1);
        bus.s_data = 64'hE1; step(1);
        bus.s_valid = 0; step(1);
        chk("pre_drops", 64'(bus.sts_drop_cnt), 64'd3);
        chk("pre_nwr",   64'(wr_q.size()),      64'd2);
        if (sync_q.size() == 2) begin
            chk("pre_sync0", 64'(sync_q[0]), 64'd1);
            chk("pre_sync1", 64'(sync_q[1]), 64'd0);
            chk("pre_data0", wr_q[0],        64'hE0);
        end
        bus.cfg_enable = 0; bus.fifo_wr_xfer_req = 0; step(2);

        // Abort after five of eight beats.
        bus.cfg_len = 20'd8; bus.cfg_enable = 1; step(1);
        bus.fifo_wr_xfer_req = 1; step(1);
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1; bus.s_data = 64'(i); step(1);
        end
        bus.s_valid = 0; bus.fifo_wr_xfer_req = 0; step(2);
        chk("ab_abort", 64'(bus.sts_abort),    64'd1);
        chk("ab_done",  64'(bus.sts_done),     64'd0);
        chk("ab_beats", 64'(bus.sts_beat_cnt), 64'd5);
        bus.cfg_enable = 0; step(2);
        bus.cfg_enable = 1; step(1);
        chk("rearm_abort", 64'(bus.sts_abort), 64'd0);

        // Request drops on the completing cycle: completion wins.
        bus.fifo_wr_xfer_req = 1; step(1);
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1; bus.s_data = 64'h80 + 64'(i);
            bus.fifo_wr_xfer_req = (i != 7); step(1);
        end
        bus.s_valid = 0; step(1);
        chk("cmp_done",  64'(bus.sts_done),     64'd1);
        chk("cmp_abort", 64'(bus.sts_abort),    64'd0);
        chk("cmp_beats", 64'(bus.sts_beat_cnt), 64'd8);
        bus.cfg_enable = 0; step(2);

        // Continuous mode with an overflow pulse.
        bus.cfg_len = '0; bus.cfg_enable = 1; step(1);
        bus.fifo_wr_xfer_req = 1; step(1);
        clear_log();
        for (int i = 0; i < 100; i++) begin
            bus.s_valid = 1; bus.s_data = 64'h1000 + 64'(i);
            bus.fifo_wr_overflow = (i == 50); step(1);
        end
        bus.s_valid = 0; bus.fifo_wr_overflow = 0; step(3);
        chk("cont_nwr",   64'(wr_q.size()),      64'd100);
        if (wr_q.size() == 100) chk("cont_last", wr_q[99], 64'h1063);
        chk("cont_ovf",   64'(bus.sts_ovf),      64'd1);
        chk("cont_busy",  64'(bus.sts_busy),     64'd1);
        chk("cont_beats", 64'(bus.sts_beat_cnt), 64'd100);
        bus.fifo_wr_xfer_req = 0; step(2);
        chk("cont_abort", 64'(bus.sts_abort), 64'd1);
        chk("cont_ovf2",  64'(bus.sts_ovf),   64'd1);
        bus.cfg_enable = 0; step(1);
        bus.cfg_enable = 1; step(1);
        chk("rearm_ovf", 64'(bus.sts_ovf), 64'd0);

        // Reset while a beat is pending, enable held high throughout.
        bus.fifo_wr_xfer_req = 1; step(2);
        bus.s_valid = 1; bus.s_data = 64'hDEAD_BEEF; step(1);
        bus.s_data = 64'hFEED_F00D;
        #2 rst_n = 1'b0;
        step(1);
        bus.s_valid = 0;
        chk("mr_wr_en", 64'(bus.fifo_wr_en),   64'd0);
        chk("mr_data",  bus.fifo_wr_data,      64'd0);
        chk("mr_busy",  64'(bus.sts_busy),     64'd0);
        chk("mr_beats", 64'(bus.sts_beat_cnt), 64'd0);
        step(1);
        rst_n = 1'b1; step(4);
        chk("mr_no_arm", 64'(bus.sts_busy), 64'd0);
        bus.cfg_enable = 0; step(1);
        bus.cfg_enable = 1; step(1);
        chk("mr_arm", 64'(bus.sts_busy), 64'd1);
        step(1);
        bus.s_valid = 1; bus.s_data = 64'h5A; step(1);
        bus.s_valid = 0;
        chk("mr_sync", 64'(bus.fifo_wr_sync), 64'd1);
        bus.cfg_enable = 0; bus.fifo_wr_xfer_req = 0; step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
